alu_seq_ctrl: RTL

Multi-cycle sequencer wrapped around the 32-bit ALU. It accepts one operation at a time over a valid/ready request channel and drives the ALU. Shift requests carry an amount of 0–31; the ALU only shifts by one bit per pass, so the block iterates it that many times. All other functions complete in one pass. The block sits between the decode/issue stage and writeback, and returns a registered result plus negative/zero status over a valid/ready response channel.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_seq_ctrl_alu.sv | 30 +++
 rtl/alu_seq_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU function codes, sequencer state encoding and decode helper.
// No logic of its own; imported by the ALU and by the sequencer.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_XOR = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SUB = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [2:0] func_sel);
    return (func_sel == ALU_SRL) || (func_sel == ALU_SLL);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_alu.sv
// 32-bit single-pass ALU: combinational, zero latency, no flow control.
// Shifts move operand0 by exactly one bit; operand1 is ignored for them.
module ALU
  import alu_pkg::*;
(
  input  logic [31:0] operand0_i,
  input  logic [31:0] operand1_i,
  input  logic [2:0]  func_sel_i,
  output logic [31:0] out_o,
  output logic [1:0]  status_o
);

  always_comb begin
    out_o = 32'd0;
    case (func_sel_i)
      ALU_ADD: out_o = operand0_i + operand1_i;
      ALU_XOR: out_o = operand0_i ^ operand1_i;
      ALU_AND: out_o = operand0_i & operand1_i;
      ALU_OR:  out_o = operand0_i | operand1_i;
      ALU_NOR: out_o = ~(operand0_i | operand1_i);
      ALU_SRL: out_o = {1'b0, operand0_i[31:1]};
      ALU_SLL: out_o = {operand0_i[30:0], 1'b0};
      ALU_SUB: out_o = operand0_i - operand1_i;
      default: out_o = 32'd0;
    endcase
  end

  assign status_o = {out_o[31], (out_o == 32'd0)};

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer around the one-bit-per-pass ALU: 1 cycle for single-pass ops, n+1 for shift by n.
// One op in flight; req_ready only in IDLE, result held in DONE until rsp_ready.
module alu_seq_ctrl
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funcSel,
  input  logic [31:0] req_operand0,
  input  logic [31:0] req_operand1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_out,
  output logic [1:0]  rsp_status
);

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  dir_q, dir_d;

  logic [31:0] alu_op0;
  logic [31:0] alu_op1;
  logic [2:0]  alu_func;
  logic [31:0] alu_out;
  logic [1:0]  alu_status;
  logic        accept;

  // While iterating, the ALU re-shifts the accumulator by one bit per cycle.
  always_comb begin
    alu_op0  = req_operand0;
    alu_op1  = req_operand1;
    alu_func = req_funcSel;
    if (state_q == S_SHIFT) begin
      alu_op0  = acc_q;
      alu_op1  = 32'd0;
      alu_func = dir_q;
    end
  end

  ALU u_alu (
    .operand0_i (alu_op0),
    .operand1_i (alu_op1),
    .func_sel_i (alu_func),
    .out_o      (alu_out),
    .status_o   (alu_status)
  );

  assign req_ready = (state_q == S_IDLE) & ~reset;
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_DONE;
          if (is_shift(req_funcSel)) begin
            acc_d = req_operand0;
            if (req_operand1[4:0] != 5'd0) begin
              cnt_d   = req_operand1[4:0];
              dir_d   = req_funcSel;
              state_d = S_SHIFT;
            end
          end else begin
            acc_d = alu_out;
          end
        end
      end
      S_SHIFT: begin
        acc_d = alu_out;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= 32'd0;
      cnt_q   <= 5'd0;
      dir_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // Status is recomputed from acc so the shift-by-zero bypass is covered too;
  // the ALU's own flags only serve as a consistency check here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (alu_status == {alu_out[31], (alu_out == 32'd0)});
    end
  end

  assign rsp_valid  = (state_q == S_DONE);
  assign rsp_out    = acc_q;
  assign rsp_status = {acc_q[31], (acc_q == 32'd0)};

endmodule
